// File: rtl/display_buffer_pkg.sv
// Shared definitions for the double-buffered display write bridge:
// FSM encoding, host ctrl bit positions and default widths.
package display_buffer_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int PIX_W_DEF  = 24;
    localparam int CTRL_W_DEF = 8;
    localparam int DEPTH_DEF  = 2048;

    localparam int CTRL_WR      = 0;
    localparam int CTRL_SWAP    = 1;
    localparam int CTRL_FILL    = 2;
    localparam int CTRL_CLR_OVR = 3;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SWAP_WAIT
    } state_t;

    // True when two or more of the WR/SWAP/FILL edges arrive together
    function automatic logic multi_cmd(input logic [2:0] e);
        return (e[0] & e[1]) | (e[0] & e[2]) | (e[1] & e[2]);
    endfunction

endpackage

// File: rtl/display_buffer_bridge_ctrl_edge_detect.sv
// Registers host ctrl/payload and emits a one-cycle rising-edge vector,
// with the payload delayed to stay aligned with its edge.
module ctrl_edge_detect #(
    parameter int W  = 8,
    parameter int DW = 35
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [W-1:0]  ctrl,
    input  logic [DW-1:0] data,
    output logic [W-1:0]  edges,
    output logic [DW-1:0] data_q
);

    logic [W-1:0]  ctrl_s1;
    logic [W-1:0]  ctrl_s2;
    logic [DW-1:0] data_s1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_s1 <= '0;
            ctrl_s2 <= '0;
            data_s1 <= '0;
            edges   <= '0;
            data_q  <= '0;
        end else begin
            ctrl_s1 <= ctrl;
            ctrl_s2 <= ctrl_s1;
            data_s1 <= data;
            edges   <= ctrl_s1 & ~ctrl_s2;
            data_q  <= data_s1;
        end
    end

endmodule

// File: rtl/display_buffer_bridge.sv
// Host PIO to double-buffered frame RAM bridge: pixel writes, back-buffer
// fill, and a front/back swap that completes on the next frame boundary.
module display_buffer_bridge
    import display_buffer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [PIX_W-1:0]  host_data,
    input  logic [CTRL_W-1:0] host_ctrl,
    input  logic              frame_sync,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    output logic              front_sel,
    output logic              busy,
    output logic              swap_pending,
    output logic              overrun
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic [CTRL_W-1:0]       edges;
    logic [ADDR_W+PIX_W-1:0] payload;
    logic [ADDR_W-1:0]       addr_e;
    logic [PIX_W-1:0]        data_e;
    logic                    ctrl_unused;

    assign ctrl_unused = ^(host_ctrl >> 4);
    assign addr_e      = payload[ADDR_W+PIX_W-1:PIX_W];
    assign data_e      = payload[PIX_W-1:0];

    ctrl_edge_detect #(.W(CTRL_W), .DW(ADDR_W+PIX_W)) u_edge (
        .clk     (clk_clk),
        .reset_n (reset_reset_n),
        .ctrl    (host_ctrl),
        .data    ({host_addr, host_data}),
        .edges   (edges),
        .data_q  (payload)
    );

    state_t            state, state_n;
    logic [ADDR_W-1:0] fill_cnt, fill_cnt_n;
    logic [PIX_W-1:0]  fill_val, fill_val_n;
    logic              front_n, swap_n, ovr_set, overrun_n, busy_n;
    logic              we_n;
    logic [ADDR_W:0]   addr_n;
    logic [PIX_W-1:0]  wdata_n;
    logic              ed_wr, ed_swap, ed_fill, ed_clr;

    assign ed_wr   = edges[CTRL_WR];
    assign ed_swap = edges[CTRL_SWAP];
    assign ed_fill = edges[CTRL_FILL];
    assign ed_clr  = edges[CTRL_CLR_OVR];

    always_comb begin
        state_n    = state;
        fill_cnt_n = fill_cnt;
        fill_val_n = fill_val;
        front_n    = front_sel;
        swap_n     = swap_pending;
        ovr_set    = 1'b0;
        we_n       = 1'b0;
        addr_n     = mem_addr;
        wdata_n    = mem_wdata;

        case (state)
            IDLE: begin
                if (multi_cmd({ed_fill, ed_swap, ed_wr})) begin
                    ovr_set = 1'b1;
                end else if (ed_wr) begin
                    if ({1'b0, addr_e} < DEPTH_L) begin
                        we_n    = 1'b1;
                        addr_n  = {~front_sel, addr_e};
                        wdata_n = data_e;
                    end else begin
                        ovr_set = 1'b1;
                    end
                end else if (ed_fill) begin
                    fill_val_n = data_e;
                    fill_cnt_n = '0;
                    state_n    = FILL;
                end else if (ed_swap) begin
                    swap_n  = 1'b1;
                    state_n = SWAP_WAIT;
                end
            end
            FILL: begin
                we_n       = 1'b1;
                addr_n     = {~front_sel, fill_cnt};
                wdata_n    = fill_val;
                fill_cnt_n = fill_cnt + 1'b1;
                if (ed_wr || ed_fill) ovr_set = 1'b1;
                if (ed_swap) swap_n = 1'b1;
                // A swap queued on the final write cycle still chains into SWAP_WAIT
                if (fill_cnt == LAST) begin
                    fill_cnt_n = '0;
                    state_n    = swap_n ? SWAP_WAIT : IDLE;
                end
            end
            SWAP_WAIT: begin
                if (ed_wr || ed_fill || ed_swap) ovr_set = 1'b1;
                if (frame_sync) begin
                    front_n = ~front_sel;
                    swap_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        overrun_n = ovr_set ? 1'b1 : (ed_clr ? 1'b0 : overrun);
        busy_n    = (state_n != IDLE);
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state        <= IDLE;
            fill_cnt     <= '0;
            fill_val     <= '0;
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            state        <= state_n;
            fill_cnt     <= fill_cnt_n;
            fill_val     <= fill_val_n;
            front_sel    <= front_n;
            swap_pending <= swap_n;
            overrun      <= overrun_n;
            busy         <= busy_n;
            mem_we       <= we_n;
            mem_addr     <= addr_n;
            mem_wdata    <= wdata_n;
        end
    end

endmodule

// File: doc/display_buffer_bridge.md
Name: display_buffer_bridge

Overview:
- Parametrised successor to the single-buffer display-buffer PIO path.
- Takes the host-side addr/data/ctrl exports and turns ctrl bit edges into commands: pixel write, back-buffer fill, overrun clear, and a swap that completes on the next frame boundary.
- Drives the write port of a double-buffered frame RAM. Exports front-buffer select to the LED scanner and status to a host-readable PIO.

Parameters:
- ADDR_W, 11, pixel address width per buffer
- PIX_W, 24, pixel data width (RGB)
- CTRL_W, 8, host ctrl width (must be >= 4)
- DEPTH, 2048, pixels per buffer (1 .. 2**ADDR_W); fill length and address limit

Ports:
- clk_clk  in  1  system clock, single domain
- reset_reset_n  in  1  synchronous active-low reset
- host_addr  in  ADDR_W  pixel address from PIO
- host_data  in  PIX_W  pixel/fill value from PIO
- host_ctrl  in  CTRL_W  command bits: [0] WR, [1] SWAP, [2] FILL, [3] CLR_OVR; other bits ignored
- frame_sync  in  1  one-cycle pulse from scanner at end of frame
- mem_we  out  1  frame RAM write enable
- mem_addr  out  ADDR_W+1  {buffer_sel, pixel_addr}
- mem_wdata  out  PIX_W  frame RAM write data
- front_sel  out  1  buffer currently displayed
- busy  out  1  state != IDLE
- swap_pending  out  1  swap requested, not yet completed
- overrun  out  1  sticky: a command was dropped

Behaviour:
- **Reset:** clock is clk_clk; reset_reset_n is synchronous and active-low. Reset takes effect on the first clock edge it is sampled low.
  - All outputs 0; front_sel = 0; state IDLE; fill counter 0; input stage and prev-ctrl registers 0.
- **Input stage:** host_addr/data/ctrl registered into stage 1 (s1). edge[i] = ctrl_s1[i] & ~ctrl_s2[i], where ctrl_s2 is the previous s1.
  - A level held high yields exactly one command.
- **Latency:** all memory outputs are registered. mem_we rises on the 3rd clock edge after host_ctrl[0] is first sampled high, and is high exactly 1 cycle.
  - mem_addr/mem_wdata carry the s1 addr/data captured with that edge.
- **Back buffer:** always ~front_sel; mem_addr MSB = ~front_sel for every write.
- **State IDLE:**
  - Exactly one of edge[0..2] set:
    - WR: if addr < DEPTH, emit one write; otherwise drop it and set overrun.
    - FILL: latch host_data as the fill value, counter := 0, go to FILL.
    - SWAP: set swap_pending, go to SWAP_WAIT.
  - More than one of edge[0..2] in the same cycle: all dropped, overrun set.
- **State FILL:**
  - mem_we = 1 every cycle, mem_addr = {~front_sel, counter}, mem_wdata = fill value. Counter increments.
  - After writing DEPTH-1, leave FILL. Total exactly DEPTH consecutive write cycles.
  - Next state is SWAP_WAIT if swap_pending is set, else IDLE.
  - WR or FILL edges during FILL: dropped, overrun set.
  - SWAP edge during FILL: sets swap_pending (queued); no overrun.
- **State SWAP_WAIT:**
  - On frame_sync: toggle front_sel, clear swap_pending, go to IDLE, all on the same edge.
  - WR/FILL/SWAP edges: dropped, overrun set.
- **frame_sync outside SWAP_WAIT:** ignored. A frame_sync in the same cycle as the IDLE->SWAP_WAIT transition is ignored; the swap waits for the next pulse.
- **CLR_OVR edge:** clears overrun in any state. If a set and a clear occur in the same cycle, set wins.
- **Status:** busy and swap_pending are registered and reflect the state after each edge.
- **Reset mid-operation:** FILL is aborted with no further writes; the back buffer is left partially filled; a pending swap is discarded.
- **Arithmetic:** fill counter is ADDR_W bits; terminal count is DEPTH-1, so there is no wrap when DEPTH == 2**ADDR_W.

Decomposition:
- Shared package display_buffer_pkg:
  - state encoding (IDLE, FILL, SWAP_WAIT);
  - ctrl bit indices (CTRL_WR=0, CTRL_SWAP=1, CTRL_FILL=2, CTRL_CLR_OVR=3);
  - default widths.
- One sub-module, ctrl_edge_detect (parametrised width, registered prev stage, sync active-low reset), producing edge vector and s1 data.
- FSM, fill counter and write mux stay in the top.

Test Plan:
- Reset, then WR with addr=0x005, data=0x12AB34, front_sel=0 -> one mem_we pulse 3 edges after ctrl rise; mem_addr=0x805, mem_wdata=0x12AB34; ctrl held high 10 cycles gives no second write.
- FILL with data=0x0000FF, DEPTH=2048 -> 2048 consecutive mem_we cycles, addrs 0x800..0xFFF, busy high throughout, then IDLE; a WR mid-fill sets overrun and adds no extra write.
- SWAP, frame_sync pulsed 5 cycles later -> swap_pending high until the sync edge; front_sel 0->1 on that edge; next WR to addr 0x003 goes to mem_addr 0x003.
- SWAP during FILL -> no overrun; fill completes all writes, enters SWAP_WAIT, front_sel toggles only on the first frame_sync after the fill ends.
- WR+FILL rising in the same cycle, and a WR with addr=DEPTH (DEPTH=1500) -> no writes, overrun=1; CLR_OVR coinciding with a new drop keeps overrun=1; a lone CLR_OVR clears it.
- reset_reset_n low for 1 cycle at fill count 100 -> mem_we=0 from the next edge, busy=0, front_sel=0, swap_pending=0.
